// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - shared types for the instruction trace buffer
// Purpose: capture FSM state encoding, FIFO entry layout, sequence width.
package riscv_trace_pkg;

  localparam int SEQ_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_t;

  // 80-bit entry: {pc, inst, seq}
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [SEQ_W-1:0] seq;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO of trace entries
// Purpose: holds captured entries between the core side and the debug drain port.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only)
//   push_valid      request to store push_entry this cycle
//   push_entry      entry to store
//   push_accepted   push_valid and there is room (counting a same-cycle pop)
//   pop_ready       consumer takes the head entry at this edge
//   pop_valid       head entry present
//   pop_entry       head entry, zero when empty
//   full, count     occupancy status
module trace_fifo
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  trace_entry_t             push_entry,
  output logic                     push_accepted,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output trace_entry_t             pop_entry,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  trace_entry_t mem_q [DEPTH];

  logic empty;
  logic pop_fire;

  // Pointers carry one extra bit so full and empty differ only in the MSB.
  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_fire      = pop_ready && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_accepted = push_valid && (!full || pop_fire);
  assign pop_valid     = !empty;
  assign count         = wr_ptr_q - rd_ptr_q;
  // Gating with empty keeps the head outputs at zero after reset without
  // having to reset the storage array.
  assign pop_entry     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_accepted) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fire)      rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_accepted) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/inst_trace_buffer.sv
// rtl/inst_trace_buffer.sv - triggered instruction trace capture
// Purpose: samples core PC/instruction, starts capture on a PC match, queues
// {pc, inst, seq} entries and drains them over a valid/ready port. The core is
// never stalled; entries that do not fit are dropped and counted.
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   pc_in, inst_in        core PC and instruction for this cycle
//   arm, stop             one-cycle control pulses
//   trigger_pc            PC that starts a capture
//   out_valid/out_ready   drain handshake; out_pc/out_inst/out_seq head entry
//   count                 FIFO occupancy
//   dropped               saturating count of captures lost to a full FIFO
//   busy                  ARMED or CAPTURE
module inst_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CAPTURE_LEN = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            pc_in,
  input  logic [31:0]            inst_in,
  input  logic                   arm,
  input  logic                   stop,
  input  logic [31:0]            trigger_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            dropped,
  output logic                   busy
);

  trace_state_t     state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [31:0]      cap_cnt_q, cap_cnt_d;
  logic [15:0]      dropped_q, dropped_d;

  logic         trig_hit;
  logic         capture;
  logic         cap_last;
  logic         push_accepted;
  logic         fifo_full;
  logic         drop_event;
  trace_entry_t push_entry;
  trace_entry_t head_entry;

  assign trig_hit = (pc_in == trigger_pc);

  // A restart in ARMED suppresses the match; in CAPTURE the current cycle is
  // still recorded and the counters restart behind it. stop always wins.
  assign capture = !stop &&
                   ((state_q == CAPTURE) ||
                    ((state_q == ARMED) && !arm && trig_hit));

  // This capture is the last one allowed for a bounded run.
  assign cap_last = (CAPTURE_LEN != 0) &&
                    ((cap_cnt_q + 32'd1) == 32'(CAPTURE_LEN));

  assign push_entry = '{pc: pc_in, inst: inst_in, seq: seq_q};

  // The FIFO only refuses a push when it is full with no pop this cycle.
  assign drop_event = capture && fifo_full && !push_accepted;

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    cap_cnt_d = cap_cnt_q;
    dropped_d = dropped_q;

    if (capture) begin
      // seq advances even on a drop so gaps reveal lost entries
      seq_d     = seq_q + 1'b1;
      cap_cnt_d = cap_cnt_q + 32'd1;
    end

    if (drop_event && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end

    if (arm) begin
      state_d   = ARMED;
      seq_d     = '0;
      cap_cnt_d = '0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (trig_hit) begin
            state_d = (stop || cap_last) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop || cap_last) state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seq_q     <= '0;
      cap_cnt_q <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      cap_cnt_q <= cap_cnt_d;
      dropped_q <= dropped_d;
    end
  end

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_valid    (capture),
    .push_entry    (push_entry),
    .push_accepted (push_accepted),
    .pop_ready     (out_ready),
    .pop_valid     (out_valid),
    .pop_entry     (head_entry),
    .full          (fifo_full),
    .count         (count)
  );

  assign out_pc   = head_entry.pc;
  assign out_inst = head_entry.inst;
  assign out_seq  = head_entry.seq;
  assign dropped  = dropped_q;
  assign busy     = (state_q == ARMED) || (state_q == CAPTURE);

endmodule
